// File: rtl/arith_sched_pkg.sv
// rtl/arith_sched_pkg.sv - shared types and constants for the arithmetic op scheduler
package arith_sched_pkg;

    localparam int W_DEFAULT = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC_ADD = 2'd1,
        EXEC_MUL = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a last-winner pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // last_id names the requester that won most recently; reset to 1 so requester 0 wins first
    logic last_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (update) begin
            last_id <= grant[1];
        end
    end

    assign grant[0] = req[0] && (!req[1] || last_id);
    assign grant[1] = req[1] && (!req[0] || !last_id);

endmodule

// File: rtl/arith_op_scheduler.sv
// rtl/arith_op_scheduler.sv - shares one add/shift-add multiply unit between two requesters
module arith_op_scheduler
    import arith_sched_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req0_op,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic           req1_op,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [2*W-1:0] rsp_data,
    output logic           busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            id_q;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic [1:0]      grant;
    logic            accept;
    logic            sel_id;
    logic            sel_op;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [2*W-1:0]  partial;
    logic [2*W-1:0]  acc_next;
    logic [W:0]      sum;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1_valid, req0_valid}),
        .update (accept),
        .grant  (grant)
    );

    assign req0_ready = (state == IDLE) && grant[0];
    assign req1_ready = (state == IDLE) && grant[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign busy       = (state != IDLE);

    // grant is one-hot whenever accept is high, so grant[1] names the winner
    assign sel_id = grant[1];
    assign sel_op = sel_id ? req1_op : req0_op;
    assign sel_a  = sel_id ? req1_a  : req0_a;
    assign sel_b  = sel_id ? req1_b  : req0_b;

    always_comb begin
        partial = '0;
        if (a_q[cnt]) begin
            partial = {{W{1'b0}}, b_q} << cnt;
        end
        acc_next = acc + partial;
        sum      = {1'b0, a_q} + {1'b0, b_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= sel_id;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= (sel_op == OP_MUL) ? EXEC_MUL : EXEC_ADD;
                    end
                end
                EXEC_ADD: begin
                    rsp_data  <= {{(W-1){1'b0}}, sum};
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                EXEC_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        rsp_data  <= acc_next;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_op_scheduler.sv
// tb/tb_arith_op_scheduler.sv - directed vector bench for arith_op_scheduler
module tb_arith_op_scheduler;

    localparam int W = 3;

    logic           clk;
    logic           rst;
    logic           req0_valid, req0_ready, req0_op;
    logic [W-1:0]   req0_a, req0_b;
    logic           req1_valid, req1_ready, req1_op;
    logic [W-1:0]   req1_a, req1_b;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*W-1:0] rsp_data;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    arith_op_scheduler #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       id;
        logic       op;
        logic [2:0] a;
        logic [2:0] b;
        int         exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic op,
                           input logic [2:0] a, input logic [2:0] b);
        if (id == 1'b0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // waits (bounded) for rsp_valid; returns number of cycles waited
    task automatic wait_rsp(input int limit, output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < limit) begin
            next_cycle();
            cyc++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  cyc;
        int  guard;
        logic rdy;
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        #1;
        guard = 0;
        rdy = v.id ? req1_ready : req0_ready;
        while (!rdy && guard < 10) begin
            next_cycle();
            guard++;
            rdy = v.id ? req1_ready : req0_ready;
        end
        check($sformatf("vec%0d_ready", idx), int'(rdy), 1);
        next_cycle();
        set_req(v.id, 1'b0, 1'b0, 3'd0, 3'd0);
        check($sformatf("vec%0d_busy", idx), int'(busy), 1);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            next_cycle();
            cyc++;
        end
        check($sformatf("vec%0d_latency", idx), cyc, v.exp_lat);
        check($sformatf("vec%0d_data", idx), int'(rsp_data), v.exp_data);
        check($sformatf("vec%0d_id", idx), int'(rsp_id), int'(v.id));
        next_cycle();
        check($sformatf("vec%0d_valid_drop", idx), int'(rsp_valid), 0);
        check($sformatf("vec%0d_idle", idx), int'(busy), 0);
    endtask

    initial begin
        int cyc;
        int guard;
        int winner;

        vecs[0] = '{1'b0, 1'b0, 3'd3, 3'd5,  8, 2};
        vecs[1] = '{1'b0, 1'b0, 3'd7, 3'd7, 14, 2};
        vecs[2] = '{1'b1, 1'b1, 3'd7, 3'd7, 49, 4};
        vecs[3] = '{1'b1, 1'b1, 3'd0, 3'd5,  0, 4};
        vecs[4] = '{1'b0, 1'b1, 3'd5, 3'd3, 15, 4};
        vecs[5] = '{1'b1, 1'b0, 3'd0, 3'd0,  0, 2};
        vecs[6] = '{1'b0, 1'b1, 3'd6, 3'd7, 42, 4};

        rst = 1'b1;
        rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        next_cycle();
        next_cycle();
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_data", int'(rsp_data), 0);
        check("reset_rsp_id", int'(rsp_id), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;
        next_cycle();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
        end

        // contention: both requesters held valid from reset
        rst = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 3'd2, 3'd1);
        set_req(1'b1, 1'b1, 1'b1, 3'd2, 3'd3);
        next_cycle();
        rst = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            guard = 0;
            while (!req0_ready && !req1_ready && guard < 10) begin
                next_cycle();
                guard++;
            end
            winner = req1_ready ? 1 : (req0_ready ? 0 : 2);
            check($sformatf("contend%0d_grant", g), winner, g % 2);
            next_cycle();
            wait_rsp(10, cyc);
            check($sformatf("contend%0d_rsp_id", g), int'(rsp_id), g % 2);
            check($sformatf("contend%0d_rsp_data", g), int'(rsp_data), (g % 2) ? 6 : 3);
            next_cycle();
        end
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        next_cycle();

        // backpressure: 6*5 held in DONE while req1 waits
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 3'd6, 3'd5);
        #1;
        check("bp_accept_ready", int'(req0_ready), 1);
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        set_req(1'b1, 1'b1, 1'b0, 3'd1, 3'd1);
        wait_rsp(10, cyc);
        check("bp_rsp_valid", int'(rsp_valid), 1);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check($sformatf("bp%0d_data", k), int'(rsp_data), 30);
            check($sformatf("bp%0d_id", k), int'(rsp_id), 0);
            check($sformatf("bp%0d_ready", k), int'({req1_ready, req0_ready}), 0);
            check($sformatf("bp%0d_valid", k), int'(rsp_valid), 1);
        end
        rsp_ready = 1'b1;
        next_cycle();
        check("bp_release_valid", int'(rsp_valid), 0);
        check("bp_release_idle", int'(busy), 0);
        check("bp_release_req1_ready", int'(req1_ready), 1);
        next_cycle();
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        wait_rsp(10, cyc);
        check("bp_next_data", int'(rsp_data), 2);
        check("bp_next_id", int'(rsp_id), 1);
        next_cycle();
        next_cycle();

        // reset during the second multiply iteration
        set_req(1'b0, 1'b1, 1'b1, 3'd7, 3'd7);
        #1;
        check("rstmid_accept_ready", int'(req0_ready), 1);
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        next_cycle();
        check("rstmid_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_rsp_valid", int'(rsp_valid), 0);
        set_req(1'b0, 1'b1, 1'b0, 3'd1, 3'd1);
        set_req(1'b1, 1'b1, 1'b0, 3'd2, 3'd2);
        next_cycle();
        check("rstmid_rsp_valid_hold", int'(rsp_valid), 0);
        rst = 1'b0;
        #1;
        check("rstmid_grant0", int'({req1_ready, req0_ready}), 1);
        next_cycle();
        set_req(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
        set_req(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
        wait_rsp(10, cyc);
        check("rstmid_next_data", int'(rsp_data), 2);
        check("rstmid_next_id", int'(rsp_id), 0);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_op_scheduler.md
Name: arith_op_scheduler

Overview:
Shares one 3-bit add/multiply resource between two requesters. Each requester issues an operation over a valid/ready handshake. A 2-way round-robin arbiter grants one request at a time. Add completes in one execute cycle; multiply runs as a W-cycle sequential shift-add. The result is returned on a single tagged response channel with backpressure. The block sits between the requesting control logic and the arithmetic datapath.

Parameters:
W, 3, operand width in bits; the result is 2*W bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  1  0 = add, 1 = multiply
req0_a  input  W  operand A
req0_b  input  W  operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts the result
rsp_id  output  1  index of the requester that owns the result
rsp_data  output  2*W  zero-extended sum, or product
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Round-robin pointer is set so that requester 0 wins the first contention.
  - All internal registers are cleared.
- States:
  - IDLE.
  - EXEC_ADD: 1 cycle.
  - EXEC_MUL: W cycles, iteration counter 0..W-1.
  - DONE.
- IDLE:
  - reqN_ready = (state==IDLE) && grantN, combinational.
  - grant goes to the only valid requester.
  - If both are valid, grant goes to the requester not granted last.
  - Acceptance occurs on valid&&ready. At acceptance:
    - capture op, a, b and id;
    - update the pointer to the granted requester;
    - go to EXEC_ADD if op=0, or EXEC_MUL if op=1.
  - A requester keeps valid and its fields stable until it is accepted. The block does not check this.
- EXEC_ADD: result = a + b, W+1 bits, zero-extended to 2*W. Next state is DONE.
- EXEC_MUL:
  - Accumulator is cleared at acceptance.
  - On iteration i: if a[i]=1, acc += b << i.
  - After iteration W-1, go to DONE with rsp_data = acc.
- DONE:
  - rsp_valid=1. rsp_data and rsp_id are held stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE and drop rsp_valid in the next cycle.
  - A new request cannot be accepted during DONE. There is a one-cycle IDLE bubble between operations.
- Latency, with acceptance in cycle T:
  - add: rsp_valid high in cycle T+2;
  - multiply: rsp_valid high in cycle T+1+W, which is T+4 for W=3.
- Backpressure: rsp_ready low holds DONE indefinitely. Both req_ready outputs stay 0 during that time.
- rsp_ready high while rsp_valid=0 has no effect.
- Simultaneous events:
  - A new request arriving while DONE completes is not accepted until the following IDLE cycle.
  - Pointer-based arbitration applies only in IDLE.
- Reset mid-operation:
  - the in-flight operation is dropped;
  - no response is produced;
  - the pointer returns to favour requester 0.
- Width: no overflow is possible. The maximum sum is 2^(W+1)-2 and the maximum product is (2^W-1)^2, both of which fit in 2*W bits.

Decomposition:
- Shared package arith_sched_pkg:
  - default W;
  - op encoding constants OP_ADD=1'b0 and OP_MUL=1'b1;
  - state enum {IDLE, EXEC_ADD, EXEC_MUL, DONE}.
- Sub-module rr_arb2: 2-way round-robin grant logic, consisting of the pointer register plus combinational grant. It has an update-enable input that is driven on acceptance.
- The FSM, shift-add datapath and response registers stay in the top module.

Test Plan:
- Add with back-to-back issue:
  - req0 add a=3, b=5 accepted at T, rsp_ready=1 -> rsp_valid at T+2, rsp_data=8, rsp_id=0, busy high T+1..T+2.
  - 7+7 -> 14.
- Multiply:
  - req1 mul a=7, b=7 -> rsp_data=49, rsp_id=1 at T+4.
  - 0*5 -> 0; 5*3 -> 15.
- Contention:
  - req0 and req1 both held valid from reset -> grants in order 0, 1, 0, 1.
  - Responses carry the matching ids and operands (0: 2+1=3; 1: 2*3=6).
- Backpressure:
  - rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data and rsp_id stable, both req_ready=0.
  - Raising rsp_ready -> single transfer, then IDLE.
- Reset mid-operation:
  - Assert rst during the second EXEC_MUL cycle -> rsp_valid stays 0, busy=0 immediately.
  - After release, with both requesters valid -> requester 0 granted first.
